// File: rtl/pov_column_loader_if.sv
// Source-pixel handshake and register-bus signals for pov_column_loader.
// master: the loader side (drives the bus, accepts pixels).
// slave:  the environment side (supplies pixels, returns read data).
interface pov_column_loader_if;
  logic        src_valid;
  logic [23:0] src_data;
  logic        src_ready;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wren;
  logic        bus_rden;
  logic [31:0] bus_rdata;

  modport master (
    input  src_valid, src_data, bus_rdata,
    output src_ready, bus_addr, bus_wdata, bus_wren, bus_rden
  );

  modport slave (
    output src_valid, src_data, bus_rdata,
    input  src_ready, bus_addr, bus_wdata, bus_wren, bus_rden
  );
endinterface

// File: rtl/pov_column_loader.sv
// Persistence-of-vision column loader: fetches one RGB pixel per column and
// writes column index, pixel and a trigger into the POV register block.
// Optional build macro POV_LOADER_SYNC_EN adds a pre-frame poll of the
// register at BASE_ADDR+12, waiting until its low byte reads zero.
module pov_column_loader #(
  parameter int unsigned N_COLS    = 256,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       abort,
  pov_column_loader_if.master        bus,
  output logic                       busy,
  output logic                       frame_done,
  output logic [7:0]                 col_idx
);

  localparam logic [7:0] LastCol = 8'(N_COLS - 1);

  typedef enum logic [2:0] {
    StIdle,
`ifdef POV_LOADER_SYNC_EN
    StSyncReq,
    StSyncWait,
`endif
    StFetch,
    StWCol,
    StWData,
    StWTrig,
    StDone
  } state_e;

  state_e      r_state, w_state_next;
  logic [7:0]  r_col, w_col_next;
  logic [23:0] r_pixel, w_pixel_next;

  logic        w_src_ready;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_wren;
  logic        w_rden;
  logic        w_done;

`ifdef POV_LOADER_SYNC_EN
  logic w_unused_rdata;
  assign w_unused_rdata = ^bus.bus_rdata[31:8];
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^bus.bus_rdata;
`endif

  // State, column counter and pixel register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_col   <= 8'h00;
      r_pixel <= 24'h000000;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_pixel <= w_pixel_next;
    end
  end

  // Next-state logic; abort wins over every other transition, including start.
  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_pixel_next = r_pixel;
    if (abort) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            w_col_next   = 8'h00;
`ifdef POV_LOADER_SYNC_EN
            w_state_next = StSyncReq;
`else
            w_state_next = StFetch;
`endif
          end
        end
`ifdef POV_LOADER_SYNC_EN
        StSyncReq:  w_state_next = StSyncWait;
        StSyncWait: w_state_next = (bus.bus_rdata[7:0] == 8'h00) ? StFetch : StSyncReq;
`endif
        StFetch: begin
          if (bus.src_valid) begin
            w_pixel_next = bus.src_data;
            w_state_next = StWCol;
          end
        end
        StWCol:  w_state_next = StWData;
        StWData: w_state_next = StWTrig;
        StWTrig: begin
          if (r_col == LastCol) begin
            w_state_next = StDone;
          end else begin
            w_col_next   = r_col + 8'd1;
            w_state_next = StFetch;
          end
        end
        StDone:  w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  // Moore outputs decoded from the current state; bus idles at all-zero.
  always_comb begin
    w_src_ready = 1'b0;
    w_addr      = 32'h0;
    w_wdata     = 32'h0;
    w_wren      = 1'b0;
    w_rden      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      StFetch: w_src_ready = 1'b1;
      StWCol: begin
        w_wren  = 1'b1;
        w_addr  = BASE_ADDR;
        w_wdata = {24'h0, r_col};
      end
      StWData: begin
        w_wren  = 1'b1;
        w_addr  = BASE_ADDR + 32'd4;
        w_wdata = {8'h0, r_pixel};
      end
      StWTrig: begin
        w_wren  = 1'b1;
        w_addr  = BASE_ADDR + 32'd8;
      end
`ifdef POV_LOADER_SYNC_EN
      StSyncReq: begin
        w_rden  = 1'b1;
        w_addr  = BASE_ADDR + 32'd12;
      end
`endif
      StDone:  w_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.src_ready = w_src_ready;
  assign bus.bus_addr  = w_addr;
  assign bus.bus_wdata = w_wdata;
  assign bus.bus_wren  = w_wren;
  assign bus.bus_rden  = w_rden;
  assign frame_done    = w_done;
  assign busy          = (r_state != StIdle);
  assign col_idx       = r_col;

endmodule
